// File: rtl/reaction_pkg.sv
// Shared types and constants for the reaction-time trial sequencer.
//   state_t    : FSM state encoding (IDLE, WAIT, GO, DONE, FAULT)
//   RT_W       : width of millisecond counters and reported times
//   BEST_NONE  : BEST_MS value meaning "no valid result since reset"
package reaction_pkg;

   localparam int unsigned RT_W    = 14;
   localparam int unsigned RAND_W  = 11;
   localparam int unsigned DELAY_W = 12;

   localparam logic [RT_W-1:0] BEST_NONE = 14'h3FFF;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      WAIT  = 3'd1,
      GO    = 3'd2,
      DONE  = 3'd3,
      FAULT = 3'd4
   } state_t;

endpackage

// File: rtl/ms_tick_gen.sv
// Millisecond tick generator.
//   clk, rst : clock, asynchronous active-high reset
//   en       : count while high; counter is held at zero while low, so a
//              rising enable always starts on a fresh millisecond
//   clr      : restart the current millisecond (phase boundary)
//   tick_c   : high for one cycle when the counter is at TICK_DIV-1
module ms_tick_gen #(
   parameter int unsigned TICK_DIV = 50000
) (
   input  logic clk,
   input  logic rst,
   input  logic en,
   input  logic clr,
   output logic tick_c
);

   localparam int unsigned     CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_DIV - 1);

   logic [CNT_W-1:0] tick_cnt;

   // Divider counter: wraps at LAST, held at zero when idle or cleared.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tick_cnt <= '0;
      end else if (clr || !en) begin
         tick_cnt <= '0;
      end else if (tick_cnt == LAST) begin
         tick_cnt <= '0;
      end else begin
         tick_cnt <= tick_cnt + CNT_W'(1);
      end
   end

   assign tick_c = en && (tick_cnt == LAST);

endmodule

// File: rtl/reaction_ctrl.sv
// Reaction-time trial sequencer: random wait, GO indicator, reaction count,
// false-start / timeout detection and best-time tracking.
//   clk, rst     : clock, asynchronous active-high reset
//   start, stop  : one-cycle pulses from the debounced buttons
//   rand_word    : LFSR word, captured only when a trial starts
//   go_led       : high while the subject must react
//   busy         : high in WAIT and GO
//   rt_ms        : last valid reaction time in ms
//   best_ms      : minimum valid reaction time since reset (BEST_NONE if none)
//   valid        : high in DONE, rt_ms is fresh
//   false_start  : high in FAULT after STOP during WAIT
//   timeout      : high in FAULT after the count reached MAX_RT_MS
module reaction_ctrl
   import reaction_pkg::*;
#(
   parameter int unsigned TICK_DIV     = 50000,
   parameter int unsigned MIN_DELAY_MS = 1000,
   parameter int unsigned MAX_RT_MS    = 9999
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              stop,
   input  logic [RAND_W-1:0] rand_word,
   output logic              go_led,
   output logic              busy,
   output logic [RT_W-1:0]   rt_ms,
   output logic [RT_W-1:0]   best_ms,
   output logic              valid,
   output logic              false_start,
   output logic              timeout
);

   localparam logic [RT_W-1:0]    MAX_CNT = RT_W'(MAX_RT_MS);
   localparam logic [DELAY_W-1:0] MIN_DLY = DELAY_W'(MIN_DELAY_MS);

   state_t              state, state_nxt;
   logic [RT_W-1:0]     ms_cnt, ms_nxt, ms_inc_c;
   logic [DELAY_W-1:0]  delay_ms, delay_nxt;
   logic [RT_W-1:0]     rt_nxt, best_nxt;
   logic                valid_nxt, fs_nxt, to_nxt;
   logic                tick_c;
   logic                phase_clr_c;

   assign ms_inc_c    = ms_cnt + RT_W'(1);
   // Every state change restarts the millisecond divider.
   assign phase_clr_c = (state_nxt != state);

   ms_tick_gen #(
      .TICK_DIV (TICK_DIV)
   ) u_tick (
      .clk    (clk),
      .rst    (rst),
      .en     (busy),
      .clr    (phase_clr_c),
      .tick_c (tick_c)
   );

   // Next-state and next-output logic.
   always_comb begin
      state_nxt = state;
      ms_nxt    = ms_cnt;
      delay_nxt = delay_ms;
      rt_nxt    = rt_ms;
      best_nxt  = best_ms;
      valid_nxt = valid;
      fs_nxt    = false_start;
      to_nxt    = timeout;

      case (state)
         IDLE, DONE, FAULT: begin
            if (start) begin
               state_nxt = WAIT;
               ms_nxt    = '0;
               // 12-bit sum cannot overflow: max 1000 + 2047
               delay_nxt = MIN_DLY + DELAY_W'(rand_word);
               valid_nxt = 1'b0;
               fs_nxt    = 1'b0;
               to_nxt    = 1'b0;
            end
         end

         WAIT: begin
            // STOP takes priority over the terminal tick.
            if (stop) begin
               state_nxt = FAULT;
               fs_nxt    = 1'b1;
            end else if (tick_c) begin
               if (ms_inc_c == RT_W'(delay_ms)) begin
                  state_nxt = GO;
                  ms_nxt    = '0;
               end else begin
                  ms_nxt = ms_inc_c;
               end
            end
         end

         GO: begin
            // STOP reports the whole ms elapsed before this cycle's tick.
            if (stop) begin
               state_nxt = DONE;
               rt_nxt    = ms_cnt;
               valid_nxt = 1'b1;
               if (ms_cnt < best_ms) begin
                  best_nxt = ms_cnt;
               end
            end else if (tick_c) begin
               ms_nxt = ms_inc_c;
               if (ms_inc_c == MAX_CNT) begin
                  state_nxt = FAULT;
                  to_nxt    = 1'b1;
               end
            end
         end

         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // State and registered outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= IDLE;
         ms_cnt      <= '0;
         delay_ms    <= '0;
         rt_ms       <= '0;
         best_ms     <= BEST_NONE;
         valid       <= 1'b0;
         false_start <= 1'b0;
         timeout     <= 1'b0;
         go_led      <= 1'b0;
         busy        <= 1'b0;
      end else begin
         state       <= state_nxt;
         ms_cnt      <= ms_nxt;
         delay_ms    <= delay_nxt;
         rt_ms       <= rt_nxt;
         best_ms     <= best_nxt;
         valid       <= valid_nxt;
         false_start <= fs_nxt;
         timeout     <= to_nxt;
         go_led      <= (state_nxt == GO);
         busy        <= (state_nxt == WAIT) || (state_nxt == GO);
      end
   end

endmodule

// File: tb/tb_reaction_ctrl.sv
// Self-checking bench for reaction_ctrl with TICK_DIV=4, MIN_DELAY_MS=10,
// MAX_RT_MS=50. The reference model works in whole clock cycles counted from
// the first WAIT cycle: the wait phase lasts TD*delay cycles, the GO phase at
// most TD*MAX cycles, and a STOP in GO cycle g reports g/TD milliseconds.
module tb_reaction_ctrl;

   localparam int TD  = 4;
   localparam int MIN = 10;
   localparam int MAX = 50;
   localparam int TRIAL_LIMIT = TD * (MIN + 2047) + TD * MAX + 16;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        start = 1'b0;
   logic        stop = 1'b0;
   logic [10:0] rand_word = '0;
   logic        go_led, busy, valid, false_start, timeout;
   logic [13:0] rt_ms, best_ms;

   int checks = 0;
   int errors = 0;

   // Expected architectural outputs outside a trial
   int m_rt   = 0;
   int m_best = 16383;
   bit m_valid = 1'b0, m_fs = 1'b0, m_to = 1'b0;

   reaction_ctrl #(
      .TICK_DIV     (TD),
      .MIN_DELAY_MS (MIN),
      .MAX_RT_MS    (MAX)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .start       (start),
      .stop        (stop),
      .rand_word   (rand_word),
      .go_led      (go_led),
      .busy        (busy),
      .rt_ms       (rt_ms),
      .best_ms     (best_ms),
      .valid       (valid),
      .false_start (false_start),
      .timeout     (timeout)
   );

   always #5 clk = ~clk;

   function automatic logic [32:0] obs_vec();
      return {valid, false_start, timeout, go_led, busy, rt_ms, best_ms};
   endfunction

   function automatic logic [32:0] exp_vec();
      return {m_valid, m_fs, m_to, 2'b00, 14'(m_rt), 14'(m_best)};
   endfunction

   function automatic void model_reset();
      m_rt = 0; m_best = 16383; m_valid = 1'b0; m_fs = 1'b0; m_to = 1'b0;
   endfunction

   // kind: 0 = valid result, 1 = false start, 2 = timeout.
   task automatic predict(input int d, input int s, output int kind,
                          output int end_c, output int go_c, output int rt);
      int wait_len, go_len;
      wait_len = TD * d;
      go_len   = TD * MAX;
      go_c = wait_len;
      rt   = 0;
      if (s >= 0 && s < wait_len) begin
         kind = 1; end_c = s; go_c = -1;
      end else if (s >= 0 && (s - wait_len) < go_len) begin
         kind = 0; end_c = s; rt = (s - wait_len) / TD;
      end else begin
         kind = 2; end_c = wait_len + go_len - 1;
      end
      case (kind)
         0: begin
            m_valid = 1'b1; m_fs = 1'b0; m_to = 1'b0; m_rt = rt;
            if (rt < m_best) m_best = rt;
         end
         1: begin m_valid = 1'b0; m_fs = 1'b1; m_to = 1'b0; end
         default: begin m_valid = 1'b0; m_fs = 1'b0; m_to = 1'b1; end
      endcase
   endtask

   // Runs one trial: STOP in WAIT-relative cycle s (-1 = never), optional
   // START poke in cycle 1. Returns the last busy cycle, GO_LED rise cycle
   // and count of GO_LED drops while still busy.
   task automatic do_trial(input logic [10:0] r, input int s, input bit poke,
                           output int o_end, output int o_rise,
                           output int o_drop, output logic o_busy0);
      int c;
      @(negedge clk); start = 1'b1; rand_word = r;
      @(negedge clk); start = 1'b0; rand_word = 11'($urandom);
      o_busy0 = busy; c = 0; o_rise = -1; o_drop = 0;
      while (busy === 1'b1 && c < TRIAL_LIMIT) begin
         if (go_led === 1'b1 && o_rise < 0) o_rise = c;
         if (go_led !== 1'b1 && o_rise >= 0) o_drop++;
         stop  = (c == s);
         start = poke && (c == 1);
         if (poke && c == 1) rand_word = 11'($urandom);
         @(negedge clk); c++;
      end
      stop = 1'b0; start = 1'b0;
      o_end = c - 1;
   endtask

   task automatic do_reset();
      @(negedge clk); rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      model_reset();
      @(negedge clk);
   endtask

   task automatic test_reset();
      rst = 1'b1;
      model_reset();
      repeat (3) @(negedge clk);
      checks++;
      if (obs_vec() !== exp_vec()) begin
         errors++; $display("FAIL reset_hold obs=%h exp=%h", obs_vec(), exp_vec());
      end
      rst = 1'b0;
      @(negedge clk); stop = 1'b1; @(negedge clk); stop = 1'b0;
      repeat (2) @(negedge clk);
      checks++;
      if (obs_vec() !== exp_vec()) begin
         errors++; $display("FAIL idle_stop_ignored obs=%h exp=%h", obs_vec(), exp_vec());
      end
   endtask

   task automatic test_trial();
      int kind, ec, gc, rt, o_end, o_rise, o_drop; logic b0;
      predict(MIN + 5, TD * (MIN + 5) + TD * 7 + 1, kind, ec, gc, rt);
      do_trial(11'd5, TD * (MIN + 5) + TD * 7 + 1, 1'b0, o_end, o_rise, o_drop, b0);
      checks++;
      if (b0 !== 1'b1) begin errors++; $display("FAIL trial_busy got=%b want=1", b0); end
      checks++;
      if (o_rise !== 60) begin errors++; $display("FAIL trial_go_rise got=%0d want=60", o_rise); end
      checks++;
      if (o_end !== ec || o_drop !== 0) begin
         errors++; $display("FAIL trial_end got=%0d/%0d want=%0d/0", o_end, o_drop, ec);
      end
      checks++;
      if (rt_ms !== 14'd7 || best_ms !== 14'd7 || valid !== 1'b1) begin
         errors++; $display("FAIL trial_rt7 rt=%0d best=%0d valid=%b want 7 7 1", rt_ms, best_ms, valid);
      end
      checks++;
      if (obs_vec() !== exp_vec()) begin
         errors++; $display("FAIL trial_outputs obs=%h exp=%h", obs_vec(), exp_vec());
      end
   endtask

   task automatic test_false_start();
      int kind, ec, gc, rt, o_end, o_rise, o_drop; logic b0;
      predict(MIN + 20, TD * 3 + 1, kind, ec, gc, rt);
      do_trial(11'd20, TD * 3 + 1, 1'b0, o_end, o_rise, o_drop, b0);
      checks++;
      if (o_rise !== -1 || o_end !== ec) begin
         errors++; $display("FAIL false_start_timing rise=%0d end=%0d want -1 %0d", o_rise, o_end, ec);
      end
      checks++;
      if (false_start !== 1'b1 || rt_ms !== 14'd7 || best_ms !== 14'd7) begin
         errors++; $display("FAIL false_start_flags fs=%b rt=%0d best=%0d want 1 7 7", false_start, rt_ms, best_ms);
      end
      checks++;
      if (obs_vec() !== exp_vec()) begin
         errors++; $display("FAIL false_start_outputs obs=%h exp=%h", obs_vec(), exp_vec());
      end
   endtask

   task automatic test_timeout();
      int kind, ec, gc, rt, o_end, o_rise, o_drop, d; logic b0; logic [10:0] r;
      r = 11'($urandom_range(0, 15));
      d = MIN + int'(r);
      predict(d, -1, kind, ec, gc, rt);
      do_trial(r, -1, 1'b0, o_end, o_rise, o_drop, b0);
      checks++;
      if (o_rise !== gc || (o_end - o_rise) !== TD * MAX - 1 || o_drop !== 0) begin
         errors++; $display("FAIL timeout_timing rise=%0d end=%0d drop=%0d want %0d %0d 0",
                            o_rise, o_end, o_drop, gc, ec);
      end
      checks++;
      if (timeout !== 1'b1 || go_led !== 1'b0 || busy !== 1'b0 || obs_vec() !== exp_vec()) begin
         errors++; $display("FAIL timeout_outputs obs=%h exp=%h", obs_vec(), exp_vec());
      end
   endtask

   task automatic test_best_tracking();
      int rts[3]  = '{12, 9, 15};
      int bests[3] = '{12, 9, 9};
      int kind, ec, gc, rt, o_end, o_rise, o_drop, d, s; logic b0; logic [10:0] r;
      do_reset();
      for (int i = 0; i < 3; i++) begin
         r = 11'($urandom_range(0, 15));
         d = MIN + int'(r);
         s = TD * d + TD * rts[i] + int'($urandom_range(0, TD - 1));
         predict(d, s, kind, ec, gc, rt);
         do_trial(r, s, 1'b1, o_end, o_rise, o_drop, b0);
         checks++;
         if (o_rise !== gc || o_end !== ec) begin
            errors++; $display("FAIL best_%0d_timing rise=%0d end=%0d want %0d %0d", i, o_rise, o_end, gc, ec);
         end
         checks++;
         if (rt_ms !== 14'(rts[i]) || best_ms !== 14'(bests[i]) || obs_vec() !== exp_vec()) begin
            errors++; $display("FAIL best_%0d rt=%0d best=%0d want %0d %0d", i, rt_ms, best_ms, rts[i], bests[i]);
         end
      end
   endtask

   task automatic test_collisions();
      int kind, ec, gc, rt, o_end, o_rise, o_drop, d, s; logic b0; logic [10:0] r;
      for (int i = 0; i < 2; i++) begin
         r = 11'($urandom_range(0, 15));
         d = MIN + int'(r);
         s = (i == 0) ? TD * d - 1 : TD * d + TD * MAX - 1;
         predict(d, s, kind, ec, gc, rt);
         do_trial(r, s, 1'b0, o_end, o_rise, o_drop, b0);
         checks++;
         if (o_rise !== gc || o_end !== ec) begin
            errors++; $display("FAIL collide_%0d_timing rise=%0d end=%0d want %0d %0d", i, o_rise, o_end, gc, ec);
         end
         checks++;
         if ((i == 0 && false_start !== 1'b1) || (i == 1 && (rt_ms !== 14'd49 || valid !== 1'b1))
             || obs_vec() !== exp_vec()) begin
            errors++; $display("FAIL collide_%0d obs=%h exp=%h", i, obs_vec(), exp_vec());
         end
      end
   endtask

   task automatic test_random();
      int kind, ec, gc, rt, o_end, o_rise, o_drop, d, s; logic b0; logic [10:0] r;
      for (int i = 0; i < 12; i++) begin
         r = (i == 0) ? 11'h7FF : 11'($urandom_range(0, 40));
         d = MIN + int'(r);
         if ($urandom_range(0, 4) == 0) s = -1;
         else if (i == 0) s = int'($urandom_range(TD * d - 4, TD * d + TD * MAX + 4));
         else s = int'($urandom_range(0, TD * (d + MAX) + 8));
         predict(d, s, kind, ec, gc, rt);
         do_trial(r, s, 1'($urandom), o_end, o_rise, o_drop, b0);
         checks++;
         if (o_rise !== gc || o_end !== ec || o_drop !== 0 || b0 !== 1'b1) begin
            errors++; $display("FAIL rand_%0d_timing rise=%0d end=%0d drop=%0d want %0d %0d 0",
                               i, o_rise, o_end, o_drop, gc, ec);
         end
         checks++;
         if (obs_vec() !== exp_vec()) begin
            errors++; $display("FAIL rand_%0d_outputs obs=%h exp=%h", i, obs_vec(), exp_vec());
         end
      end
   endtask

   task automatic test_reset_mid_go();
      int n;
      @(negedge clk); start = 1'b1; rand_word = 11'd3;
      @(negedge clk); start = 1'b0;
      n = 0;
      while (go_led !== 1'b1 && n < 1000) begin @(negedge clk); n++; end
      checks++;
      if (go_led !== 1'b1) begin errors++; $display("FAIL rst_go_reach go=%b want=1", go_led); end
      repeat (5) @(negedge clk);
      #2 rst = 1'b1;
      #1;
      model_reset();
      checks++;
      if (obs_vec() !== exp_vec()) begin
         errors++; $display("FAIL rst_mid_go_async obs=%h exp=%h", obs_vec(), exp_vec());
      end
      @(negedge clk); rst = 1'b0;
      repeat (3) @(negedge clk);
      checks++;
      if (obs_vec() !== exp_vec()) begin
         errors++; $display("FAIL rst_mid_go_idle obs=%h exp=%h", obs_vec(), exp_vec());
      end
   endtask

   initial begin
      test_reset();
      test_trial();
      test_false_start();
      test_timeout();
      test_best_tracking();
      test_collisions();
      test_random();
      test_reset_mid_go();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
